// File: rtl/sync_channel_arbiter_if.sv
// Shared pulse channel between N producers, the arbiter and one reader.
// The arbiter connects through the slave modport; the producer/reader side uses master.
interface sync_channel_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_q;
  logic [N-1:0]   in_sync;
  logic           ovf_clr;
  logic [W-1:0]   q;
  logic           sync;
  logic [SW-1:0]  src;
  logic [N-1:0]   ovf;

  modport master (output in_q, in_sync, ovf_clr, input  q, sync, src, ovf);
  modport slave  (input  in_q, in_sync, ovf_clr, output q, sync, src, ovf);
endinterface

// File: rtl/sync_channel_arbiter.sv
// Round-robin arbiter draining one-entry per-source slots onto a single q/sync channel.
// Define SYNC_ARB_OVERWRITE_EN to keep the newest sample on overflow (default keeps the oldest).
module sync_channel_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input logic clk,
  input logic reset,
  sync_channel_arbiter_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  idx;
  logic [W-1:0]   slot_d [N];
  logic [N-1:0]   slot_v, slot_v_nxt, slot_ld, ovf_set;
  logic           gnt_fire;
  logic [SW-1:0]  gnt_idx;
  logic [N-1:0]   gnt_oh;
  logic [W-1:0]   q_r, q_nxt;
  logic           sync_r, sync_nxt;
  logic [SW-1:0]  src_r, src_nxt;
  logic [N-1:0]   ovf_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // IDLE leaves as soon as any slot holds data; HOLD burns GAP cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (|slot_v) state_nxt = SEND;
      SEND: begin
        state_nxt = HOLD;
        cnt_nxt   = 4'(GAP);
      end
      HOLD: begin
        if (cnt <= 4'd1) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant search starts just after the last served source.
  always_comb begin
    gnt_fire = 1'b0;
    gnt_idx  = '0;
    idx      = '0;
    if (state == IDLE) begin
      for (int k = 1; k <= N; k++) begin
        idx = SW'((int'(ptr) + k) % N);
        if (!gnt_fire && slot_v[idx]) begin
          gnt_fire = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
    gnt_oh = '0;
    if (gnt_fire) gnt_oh[gnt_idx] = 1'b1;
    q_nxt    = '0;
    sync_nxt = 1'b0;
    src_nxt  = '0;
    if (gnt_fire) begin
      q_nxt    = slot_d[gnt_idx];
      sync_nxt = 1'b1;
      src_nxt  = gnt_idx;
    end
  end

  // A slot freed by this edge's grant accepts new data without flagging overflow.
  always_comb begin
    slot_v_nxt = slot_v;
    slot_ld    = '0;
    ovf_set    = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_sync[i]) begin
        if (!slot_v[i] || gnt_oh[i]) begin
          slot_v_nxt[i] = 1'b1;
          slot_ld[i]    = 1'b1;
        end else begin
          ovf_set[i] = 1'b1;
`ifdef SYNC_ARB_OVERWRITE_EN
          slot_ld[i] = 1'b1;
`endif
        end
      end else if (gnt_oh[i]) begin
        slot_v_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      ptr    <= SW'(N - 1);
      slot_v <= '0;
      q_r    <= '0;
      sync_r <= 1'b0;
      src_r  <= '0;
      ovf_r  <= '0;
    end else begin
      cnt    <= cnt_nxt;
      if (gnt_fire) ptr <= gnt_idx;
      slot_v <= slot_v_nxt;
      q_r    <= q_nxt;
      sync_r <= sync_nxt;
      src_r  <= src_nxt;
      ovf_r  <= (bus.ovf_clr ? '0 : ovf_r) | ovf_set;
    end
  end

  // Slot payload is qualified by slot_v, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (slot_ld[i]) slot_d[i] <= bus.in_q[i*W +: W];
    end
  end

  assign bus.q    = q_r;
  assign bus.sync = sync_r;
  assign bus.src  = src_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_sync_channel_arbiter.sv
// Bench for sync_channel_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a slot/queue-level reference model.
`timescale 1ns/1ps
module tb_sync_channel_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 1;

`ifdef SYNC_ARB_OVERWRITE_EN
  localparam logic [W-1:0] OVF_EXP = 8'hA1;
`else
  localparam logic [W-1:0] OVF_EXP = 8'hA0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   cmp_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  sync_channel_arbiter_if #(.N(N), .W(W)) bus ();

  sync_channel_arbiter #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending samples per source, last-served index, and the
  // earliest cycle at which the channel may grant again.
  logic [W-1:0] m_d [N];
  bit           m_v [N];
  int           m_ptr, cyc, next_free;
  logic [W-1:0] e_q;
  logic         e_sync;
  int           e_src;
  logic [N-1:0] e_ovf;

  task automatic model_step();
    int g;
    logic [N-1:0] nov;
    if (reset) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_ptr = N - 1; cyc = 0; next_free = 0;
      e_q = '0; e_sync = 1'b0; e_src = 0; e_ovf = '0;
    end else begin
      g = -1;
      if (cyc >= next_free)
        for (int k = 1; k <= N; k++)
          if (g < 0 && m_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      nov = bus.ovf_clr ? '0 : e_ovf;
      if (g >= 0) begin
        e_sync = 1'b1; e_q = m_d[g]; e_src = g;
        m_ptr = g; m_v[g] = 1'b0; next_free = cyc + GAP + 2;
      end else begin
        e_sync = 1'b0; e_q = '0; e_src = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.in_sync[i]) begin
          if (!m_v[i]) begin
            m_v[i] = 1'b1; m_d[i] = bus.in_q[i*W +: W];
          end else begin
            nov[i] = 1'b1;
`ifdef SYNC_ARB_OVERWRITE_EN
            m_d[i] = bus.in_q[i*W +: W];
`endif
          end
        end
      end
      e_ovf = nov;
      cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cmp_sync", 32'(bus.sync), 32'(e_sync));
      chk("cmp_q",    32'(bus.q),    32'(e_q));
      chk("cmp_src",  32'(bus.src),  32'(e_src));
      chk("cmp_ovf",  32'(bus.ovf),  32'(e_ovf));
    end
  end

  function automatic logic [N*W-1:0] pk(input int s, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[s*W +: W] = v;
    return r;
  endfunction

  task automatic step(input logic [N-1:0] m, input logic [N*W-1:0] d, input logic clr);
    @(negedge clk);
    bus.in_sync = m;
    bus.in_q    = d;
    bus.ovf_clr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    bus.in_sync = '0; bus.in_q = '0; bus.ovf_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_pulse(input string name, input int s, input logic [W-1:0] v);
    chk({name, "_sync"}, 32'(bus.sync), 32'd1);
    chk({name, "_src"},  32'(bus.src),  32'(s));
    chk({name, "_q"},    32'(bus.q),    32'(v));
  endtask

  initial begin
    bus.in_sync = '0; bus.in_q = '0; bus.ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_sync", 32'(bus.sync), 0);
    chk("rst_src", 32'(bus.src), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);

    // single source, latency two cycles
    idle(9);
    step(4'b0100, pk(2, 8'h5A), 1'b0);
    step('0, '0, 1'b0);
    chk("t1_sync11", 32'(bus.sync), 0);
    chk("t1_q11", 32'(bus.q), 0);
    step('0, '0, 1'b0);
    chk_pulse("t1_12", 2, 8'h5A);
    step('0, '0, 1'b0);
    chk("t1_sync13", 32'(bus.sync), 0);
    chk("t1_q13", 32'(bus.q), 0);

    // four simultaneous sources, served 0..3 three cycles apart
    do_reset();
    step(4'hF, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step('0, '0, 1'b0);
      if (c % 3 == 2) chk_pulse("t2", (c - 2) / 3, W'(8'h10 + (c - 2) / 3));
      else            chk("t2_gap_sync", 32'(bus.sync), 0);
    end
    chk("t2_ovf", 32'(bus.ovf), 0);

    // overflow while another source occupies the channel
    do_reset();
    step(4'b0001, pk(0, 8'h33), 1'b0);
    step('0, '0, 1'b0);
    step(4'b0010, pk(1, 8'hA0), 1'b0);
    step(4'b0010, pk(1, 8'hA1), 1'b0);
    step('0, '0, 1'b0);
    chk("t3_ovf_set", 32'(bus.ovf), 32'h2);
    step('0, '0, 1'b0);
    chk_pulse("t3_out", 1, OVF_EXP);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    chk("t3_ovf_clr", 32'(bus.ovf), 0);

    // capture on the grant edge of the same slot
    do_reset();
    step(4'b1000, pk(3, 8'h77), 1'b0);
    step(4'b1000, pk(3, 8'h78), 1'b0);
    step('0, '0, 1'b0);
    chk_pulse("t4_a", 3, 8'h77);
    idle(3);
    chk_pulse("t4_b", 3, 8'h78);
    chk("t4_ovf", 32'(bus.ovf), 0);

    // pointer continuity: after src 1, src 2 precedes src 0
    do_reset();
    step(4'b0010, pk(1, 8'h21), 1'b0);
    step(4'b0101, pk(0, 8'h20) | pk(2, 8'h22), 1'b0);
    step('0, '0, 1'b0);
    chk_pulse("t5_1", 1, 8'h21);
    idle(3);
    chk_pulse("t5_2", 2, 8'h22);
    idle(3);
    chk_pulse("t5_0", 0, 8'h20);

    // asynchronous reset while sync is high
    do_reset();
    step(4'b0100, pk(2, 8'h41), 1'b0);
    step(4'b0100, pk(2, 8'h42), 1'b0);
    step(4'b0100, pk(2, 8'h43), 1'b0);
    step(4'b0001, pk(0, 8'h40), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk_pulse("t6_pre", 0, 8'h40);
    chk("t6_pre_ovf", 32'(bus.ovf), 32'h4);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_sync", 32'(bus.sync), 0);
    chk("t6_rst_q", 32'(bus.q), 0);
    chk("t6_rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    chk("t6_discard", 32'(bus.sync), 0);
    step(4'b1010, pk(1, 8'h51) | pk(3, 8'h53), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk_pulse("t6_first", 1, 8'h51);
    idle(3);
    chk_pulse("t6_second", 3, 8'h53);

    // randomized traffic with occasional clears and resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0]   m;
      logic [N*W-1:0] d;
      m = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) m[i] = 1'b1;
        d[i*W +: W] = W'($urandom);
      end
      step(m, d, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
